// File: rtl/hazard_unit_mdu.sv
// Hazard unit for the 5-stage MIPS core: D/E forwarding selects, load-use, branch,
// RAW (stall-only mode) and MDU-busy stalls, plus a saturating stall-cycle counter.
module hazard_unit_mdu #(
  parameter int REGW    = 5,
  parameter int MDU_LAT = 4,
  parameter int FWD_EN  = 1,
  parameter int CNTW    = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [REGW-1:0] rsD,
  input  logic [REGW-1:0] rtD,
  input  logic [REGW-1:0] rsE,
  input  logic [REGW-1:0] rtE,
  input  logic [REGW-1:0] writeregE,
  input  logic [REGW-1:0] writeregM,
  input  logic [REGW-1:0] writeregW,
  input  logic            regwriteE,
  input  logic            regwriteM,
  input  logic            regwriteW,
  input  logic            memtoregE,
  input  logic            memtoregM,
  input  logic            branchD,
  input  logic            branchneD,
  input  logic            mduD,
  input  logic            hiloreadD,
  input  logic            mdustartE,
  input  logic            clrcnt,
  output logic            forwardaD,
  output logic            forwardbD,
  output logic [1:0]      forwardaE,
  output logic [1:0]      forwardbE,
  output logic            stallF,
  output logic            stallD,
  output logic            flushE,
  output logic            mdubusy,
  output logic            mdudone,
  output logic [CNTW-1:0] stallcnt
);

  localparam bit         FwdOn  = (FWD_EN != 0);
  localparam logic [7:0] MduLat = 8'(MDU_LAT);

  // Index 0 is the rs source, index 1 the rt source.
  logic [REGW-1:0] srcD [2];
  logic [REGW-1:0] srcE [2];
  logic [1:0]      dHitE, dHitM, dHitW;
  logic [1:0]      eHitM, eHitW;
  logic [1:0]      fwdSelD;
  logic [1:0]      fwdSelE [2];

  assign srcD[0] = rsD;
  assign srcD[1] = rtD;
  assign srcE[0] = rsE;
  assign srcE[1] = rtE;

  // Register 0 is hard-wired, so a zero source never counts as a hit.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : gSrc
      assign dHitE[gi] = (srcD[gi] != '0) && (srcD[gi] == writeregE);
      assign dHitM[gi] = (srcD[gi] != '0) && (srcD[gi] == writeregM);
      assign dHitW[gi] = (srcD[gi] != '0) && (srcD[gi] == writeregW);
      assign eHitM[gi] = (srcE[gi] != '0) && (srcE[gi] == writeregM);
      assign eHitW[gi] = (srcE[gi] != '0) && (srcE[gi] == writeregW);

      assign fwdSelD[gi] = FwdOn && dHitM[gi] && regwriteM;

      // The M result is younger than W, so it wins when both match.
      always_comb begin
        fwdSelE[gi] = 2'b00;
        if (FwdOn) begin
          if (eHitM[gi] && regwriteM)      fwdSelE[gi] = 2'b10;
          else if (eHitW[gi] && regwriteW) fwdSelE[gi] = 2'b01;
        end
      end
    end
  endgenerate

  assign forwardaD = fwdSelD[0];
  assign forwardbD = fwdSelD[1];
  assign forwardaE = fwdSelE[0];
  assign forwardbE = fwdSelE[1];

  logic lwStall, brStall, rawStall, mduStall;
  logic [7:0] mduCnt;

  assign lwStall  = memtoregE && (rtE != '0) && ((rtE == rsD) || (rtE == rtD));
  assign brStall  = (branchD || branchneD) &&
                    ((regwriteE && (|dHitE)) || (memtoregM && (|dHitM)));
  // Without bypass paths every in-flight producer of a D source must drain first.
  assign rawStall = !FwdOn && ((regwriteE && (|dHitE)) ||
                               (regwriteM && (|dHitM)) ||
                               (regwriteW && (|dHitW)));
  assign mduStall = mdubusy && (mduD || hiloreadD);

  assign stallD = lwStall || brStall || rawStall || mduStall;
  assign stallF = stallD;
  assign flushE = stallD;

  // A new issue restarts the countdown even if a previous op is still running.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)             mduCnt <= 8'd0;
    else if (mdustartE)     mduCnt <= MduLat;
    else if (mduCnt != 8'd0) mduCnt <= mduCnt - 8'd1;
  end

  assign mdubusy = (mduCnt != 8'd0);
  assign mdudone = (mduCnt == 8'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                         stallcnt <= '0;
    else if (clrcnt)                    stallcnt <= '0;
    else if (stallD && stallcnt != '1)  stallcnt <= stallcnt + 1'b1;
  end

endmodule
